// File: rtl/regfile_sweep.sv
`default_nettype none
// ============================================================================
//  Module   : regfile_sweep
//  Purpose  : Parametrised two-read / one-write register file for the
//             single-cycle MIPS datapath. It adds:
//               - an asynchronous active-high reset that starts a clear sweep,
//               - a clear sequencer that zeroes every entry on request (clr),
//               - an optional hard-wired zero register (ZERO_REG),
//               - an optional same-cycle write-to-read bypass, enabled by
//                 defining the macro REGFILE_BYPASS_EN.
//             busy is high while the sweep runs. It stalls the PC, and it
//             forces both read ports to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module regfile_sweep #(
   parameter int ADD_WIDTH  = 5,
   parameter int DATA_WIDTH = 32,
   parameter int ZERO_REG   = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clr,
   input  logic [ADD_WIDTH-1:0]  A1,
   input  logic [ADD_WIDTH-1:0]  A2,
   input  logic [ADD_WIDTH-1:0]  A3,
   input  logic [DATA_WIDTH-1:0] WD3,
   input  logic                  WE3,
   output logic [DATA_WIDTH-1:0] RD1,
   output logic [DATA_WIDTH-1:0] RD2,
   output logic                  busy
);

   localparam int                 c_depth = 2 ** ADD_WIDTH;
   localparam logic [ADD_WIDTH-1:0] c_last = {ADD_WIDTH{1'b1}};
   localparam logic [ADD_WIDTH-1:0] c_one  = {{(ADD_WIDTH-1){1'b0}}, 1'b1};

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_SWEEP = 1'b1
   } state_t;

   state_t                r_state;
   logic [ADD_WIDTH-1:0]  r_cnt;
   logic                  r_busy;
   logic [DATA_WIDTH-1:0] r_mem [c_depth];

   logic                  w_sweep_wr;
   logic                  w_zero_wr;
   logic                  w_wr_ok;

   // A write to entry 0 is discarded when entry 0 is hard-wired to zero.
   assign w_zero_wr  = (ZERO_REG != 0) && (A3 == '0);
   // Each edge in SWEEP clears the entry that cnt points to.
   assign w_sweep_wr = (r_state == ST_SWEEP);
   // User writes are accepted only in IDLE. In SWEEP they are dropped, not queued.
   assign w_wr_ok    = (r_state == ST_IDLE) && WE3 && !w_zero_wr;

   // Clear sequencer: reset or an accepted clr starts a sweep from entry 0.
   // busy comes straight from a flop, so it cannot glitch.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ST_SWEEP;
         r_cnt   <= '0;
         r_busy  <= 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               // The accepting edge does no clear write. A write at this
               // same edge still commits, and a later sweep edge zeroes it.
               if (clr) begin
                  r_state <= ST_SWEEP;
                  r_cnt   <= '0;
                  r_busy  <= 1'b1;
               end
            end
            ST_SWEEP: begin
               // clr is ignored here. Only rst restarts a running sweep.
               if (r_cnt == c_last) begin
                  r_state <= ST_IDLE;
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
               end else begin
                  r_cnt   <= r_cnt + c_one;
               end
            end
            default: begin
               r_state <= ST_SWEEP;
               r_cnt   <= '0;
               r_busy  <= 1'b1;
            end
         endcase
      end
   end

   // Storage array. It has no reset: the sweep zeroes it one entry per edge.
   always_ff @(posedge clk) begin
      if (w_sweep_wr) begin
         r_mem[r_cnt] <= '0;
      end else if (w_wr_ok) begin
         r_mem[A3] <= WD3;
      end
   end

   assign busy = r_busy;

   // Two identical combinational read ports. Port 0 serves A1, port 1 serves A2.
   generate
      for (genvar p = 0; p < 2; p++) begin : g_rd
         logic [ADD_WIDTH-1:0]  w_addr;
         logic [DATA_WIDTH-1:0] w_data;
         logic                  w_zero_rd;

         assign w_addr    = (p == 0) ? A1 : A2;
         assign w_zero_rd = (ZERO_REG != 0) && (w_addr == '0);

         // Read mux. busy and the zero register both override the array
         // and the bypass path.
         always_comb begin
            w_data = r_mem[w_addr];
`ifdef REGFILE_BYPASS_EN
            // Forward write data that is landing at this edge to the same address.
            if (w_wr_ok && (w_addr == A3)) begin
               w_data = WD3;
            end
`endif
            if (r_busy || w_zero_rd) begin
               w_data = '0;
            end
         end
      end
   endgenerate

   assign RD1 = g_rd[0].w_data;
   assign RD2 = g_rd[1].w_data;

endmodule
`default_nettype wire
